ad9361_burst_gate: RTL and testbench

Triggered burst capture stage sitting directly downstream of the AD9361 dual-channel AXI-stream packer. Consumes packed 4-channel I/Q words continuously, keeps a short pre-trigger history, and on an amplitude trigger emits exactly one framed burst of `BURST_LENGTH` words with `tlast`. Feeds the correlator/DMA path so only signal-bearing bursts leave the front end.

---
 rtl/ad9361_burst_gate.sv | 202 ++++++++++++++++++++
 tb/tb_ad9361_burst_gate.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_burst_gate.sv
// Triggered burst capture behind the AD9361 packer: keeps a pre-trigger history ring and emits one tlast-framed burst per trigger.
// Define AD9361_BURST_GATE_ANY_CHANNEL_EN to trigger on any of the four channels instead of channel 0 only.

module ad9361_burst_gate #(
    parameter int PRECISION    = 12,
    parameter int PRE_TRIGGER  = 16,
    parameter int BURST_LENGTH = 512,
    parameter int HOLDOFF      = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [8*PRECISION-1:0] s_axis_tdata,
    input  logic [PRECISION:0]     threshold,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [8*PRECISION-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   trig
);
    localparam int W      = 8 * PRECISION;
    localparam int PTR_W  = $clog2(PRE_TRIGGER);
    localparam int FILL_W = PTR_W + 1;
    localparam int CNT_W  = $clog2(BURST_LENGTH);
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PRE_TRIGGER);
    localparam logic [FILL_W-1:0] FILL_ARM   = FILL_W'(PRE_TRIGGER - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(PRE_TRIGGER - 1);
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LENGTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // |x| widened by one bit, so the most negative code maps to 2^(P-1) without saturation.
    function automatic logic [PRECISION:0] mag(input logic [PRECISION-1:0] x);
        logic [PRECISION:0] ext;
        ext = {x[PRECISION-1], x};
        return x[PRECISION-1] ? (~ext + (PRECISION+1)'(1)) : ext;
    endfunction

    // Channel ch occupies lanes 7-2*ch (I) and 6-2*ch (Q).
    function automatic logic [PRECISION:0] chan_metric(input logic [W-1:0] word, input int ch);
        return mag(word[(7-2*ch)*PRECISION +: PRECISION]) + mag(word[(6-2*ch)*PRECISION +: PRECISION]);
    endfunction

    logic trig_hit;
`ifdef AD9361_BURST_GATE_ANY_CHANNEL_EN
    always_comb begin
        trig_hit = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            if (chan_metric(s_axis_tdata, ch) >= threshold) trig_hit = 1'b1;
        end
    end
`else
    assign trig_hit = (chan_metric(s_axis_tdata, 0) >= threshold);
`endif

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [W-1:0]      m_data_q, m_data_d;
    logic              run_q, busy_q, trig_q;
    logic              s_accept, out_free, hist_wr, fire;
    logic [W-1:0]      hist_mem [PRE_TRIGGER];

    // run_q keeps the input closed while reset is held.
    always_comb begin
        s_axis_tready = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_IDLE, ST_HOLD: s_axis_tready = 1'b1;
                ST_STREAM:        s_axis_tready = out_free;
                default:          s_axis_tready = 1'b0;
            endcase
        end
    end

    assign out_free = !m_valid_q || m_axis_tready;
    assign s_accept = s_axis_tvalid && s_axis_tready;
    assign hist_wr  = (state_q == ST_IDLE) && s_accept;
    assign fire     = hist_wr && trig_hit && (threshold != '0) && (fill_q >= FILL_ARM);

    // NOTE: the history ring is not reset; after reset fill_q forces PRE_TRIGGER fresh writes before any read.
    always_ff @(posedge clk) begin
        if (hist_wr) hist_mem[wr_ptr_q] <= s_axis_tdata;
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value so no branch infers a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        hold_cnt_d = hold_cnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_accept) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
                    if (fire) begin
                        state_d  = ST_FLUSH;
                        rd_ptr_d = wr_ptr_q + PTR_W'(1);
                        cnt_d    = '0;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = hist_mem[rd_ptr_q];
                    m_last_d  = 1'b0;
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == FLUSH_LAST) state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (s_accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_tdata;
                    m_last_d  = (cnt_q == BURST_LAST);
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == BURST_LAST) begin
                        hold_cnt_d = '0;
                        if (HOLDOFF == 0) begin
                            state_d = ST_IDLE;
                            fill_d  = '0;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            default: begin
                if (s_accept) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        fill_d  = '0;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            run_q      <= 1'b1;
            busy_q     <= (state_d != ST_IDLE);
            trig_q     <= fire;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign busy          = busy_q;
    assign trig          = trig_q;

endmodule

// File: tb/tb_ad9361_burst_gate.sv
// Directed self-checking bench for ad9361_burst_gate: inputs change 1 ns after posedge, outputs are sampled on negedge.
`timescale 1ns/1ps

module tb_ad9361_burst_gate;
    localparam int P  = 12;
    localparam int W  = 8 * P;
    localparam int PT = 16;
    localparam int BL = 512;
    localparam int HO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic [P:0]   threshold = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;
    logic         trig;

    ad9361_burst_gate #(
        .PRECISION(P), .PRE_TRIGGER(PT), .BURST_LENGTH(BL), .HOLDOFF(HO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
        .threshold(threshold),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
        .m_axis_tlast(m_last), .busy(busy), .trig(trig)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    int           cyc;
    logic [W-1:0] src_q[$];
    logic [W-1:0] out_q[$];
    logic         out_last_q[$];
    int           acc_cyc_q[$];
    int           trig_cyc_q[$];
    int           first_valid_cyc, first_busy_cyc, last_out_cyc;
    int           valid_cnt, busy_cnt, stall_err;
    bit           rand_rdy = 1'b0;
    logic         prev_stall;
    logic [W-1:0] prev_data;

    // Lanes 7/6 carry channel-0 I/Q; lanes 5..0 carry a tag in 4-bit pieces so other channels stay small.
    function automatic logic [W-1:0] mk_word(input int i0, input int q0, input int tag);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < 6; k++) w[k*P +: P] = P'((tag >> (4*k)) & 15);
        w[7*P +: P] = P'(i0);
        w[6*P +: P] = P'(q0);
        return w;
    endfunction

    // Channel-0 metric 60 + 40 = 100.
    function automatic logic [W-1:0] qword(input int k);
        return mk_word(60, -40, k);
    endfunction

    task automatic cycle();
        logic hs_in;
        s_valid = (src_q.size() != 0);
        if (s_valid) s_data = src_q[0];
        else s_data = '0;
        m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        cyc++;
        hs_in = s_valid & s_ready;
        if (hs_in) acc_cyc_q.push_back(cyc);
        if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            out_last_q.push_back(m_last);
            last_out_cyc = cyc;
        end
        if (m_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (busy) begin
            busy_cnt++;
            if (first_busy_cyc < 0) first_busy_cyc = cyc;
        end
        if (trig) trig_cyc_q.push_back(cyc);
        if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        @(posedge clk);
        #1;
        if (hs_in) void'(src_q.pop_front());
    endtask

    task automatic run_until_out(input int n, input int budget);
        for (int i = 0; i < budget && out_q.size() < n; i++) cycle();
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        src_q.delete();
        out_q.delete();
        out_last_q.delete();
        acc_cyc_q.delete();
        trig_cyc_q.delete();
        cyc = 0;
        first_valid_cyc = -1;
        first_busy_cyc  = -1;
        last_out_cyc    = -1;
        valid_cnt  = 0;
        busy_cnt   = 0;
        stall_err  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 1'b1;
        s_data = {8{12'h7FF}};
        threshold = 13'd1;
        @(negedge clk);
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b expected 0", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b expected 0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b expected 0", m_last); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL reset_tdata: got %h expected 0", m_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (trig !== 1'b0) begin bad++; $display("FAIL reset_trig: got %b expected 0", trig); end
        reset_dut();
        @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_tready: got %b expected 1", s_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int t, errs, first_bad, lasts;
        reset_dut();
        threshold = 13'd50;
        for (int k = 0; k < PT - 1; k++) src_q.push_back(qword(k));
        repeat (25) cycle();
        total++; if (trig_cyc_q.size() != 0) begin bad++; $display("FAIL basic_partial_trig: got %0d pulses expected 0", trig_cyc_q.size()); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL basic_partial_busy: got %0d busy cycles expected 0", busy_cnt); end
        total++; if (acc_cyc_q.size() != PT - 1) begin bad++; $display("FAIL basic_partial_accept: got %0d expected %0d", acc_cyc_q.size(), PT - 1); end
        for (int k = PT - 1; k < BL; k++) src_q.push_back(qword(k));
        run_until_out(BL, 1500);
        repeat (10) cycle();
        t = (acc_cyc_q.size() > PT - 1) ? acc_cyc_q[PT-1] : -1000;
        total++; if (trig_cyc_q.size() != 1) begin bad++; $display("FAIL basic_trig_count: got %0d expected 1", trig_cyc_q.size()); end
        total++; if (trig_cyc_q.size() < 1 || trig_cyc_q[0] != t + 1) begin bad++; $display("FAIL basic_trig_time: got %0d expected %0d", (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : -1, t + 1); end
        total++; if (first_busy_cyc != t + 1) begin bad++; $display("FAIL basic_busy_time: got %0d expected %0d", first_busy_cyc, t + 1); end
        total++; if (first_valid_cyc != t + 2) begin bad++; $display("FAIL basic_first_valid: got %0d expected %0d", first_valid_cyc, t + 2); end
        total++; if (last_out_cyc != t + 2 + BL - 1) begin bad++; $display("FAIL basic_no_bubbles: last word at %0d expected %0d", last_out_cyc, t + 2 + BL - 1); end
        total++; if (out_q.size() != BL) begin bad++; $display("FAIL basic_out_count: got %0d expected %0d", out_q.size(), BL); end
        errs = 0; first_bad = -1; lasts = 0;
        for (int k = 0; k < out_q.size(); k++) begin
            if (out_q[k] !== qword(k)) begin errs++; if (first_bad < 0) first_bad = k; end
            if (out_last_q[k]) lasts++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL basic_data: got %0d wrong words (first %0d) expected 0", errs, first_bad); end
        total++; if (lasts != 1 || out_q.size() != BL || out_last_q[BL-1] !== 1'b1) begin bad++; $display("FAIL basic_tlast: got %0d tlasts expected 1 on word %0d", lasts, BL - 1); end
    endtask

    task automatic test_threshold_zero();
        reset_dut();
        threshold = '0;
        for (int k = 0; k < 2000; k++) src_q.push_back({8{12'h800}});
        repeat (2010) cycle();
        total++; if (valid_cnt != 0) begin bad++; $display("FAIL zero_thr_valid: got %0d valid cycles expected 0", valid_cnt); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL zero_thr_busy: got %0d busy cycles expected 0", busy_cnt); end
        total++; if (acc_cyc_q.size() != 2000) begin bad++; $display("FAIL zero_thr_accept: got %0d expected 2000", acc_cyc_q.size()); end
    endtask

    task automatic test_boundary();
        reset_dut();
        threshold = 13'd4097;
        for (int k = 0; k < 20; k++) src_q.push_back(mk_word(-2048, -2048, k));
        repeat (30) cycle();
        total++; if (trig_cyc_q.size() != 0) begin bad++; $display("FAIL bound_4097: got %0d pulses expected 0", trig_cyc_q.size()); end
        threshold = 13'd4096;
        src_q.push_back(mk_word(-2048, -2048, 20));
        repeat (5) cycle();
        total++; if (trig_cyc_q.size() != 1) begin bad++; $display("FAIL bound_4096: got %0d pulses expected 1", trig_cyc_q.size()); end
        total++; if (trig_cyc_q.size() < 1 || acc_cyc_q.size() != 21 || trig_cyc_q[0] != acc_cyc_q[20] + 1) begin
            bad++; $display("FAIL bound_trig_time: got %0d pulses/%0d accepts expected pulse 1 cycle after word 20", trig_cyc_q.size(), acc_cyc_q.size());
        end
    endtask

    task automatic test_backpressure();
        int errs, first_bad, lasts;
        reset_dut();
        threshold = 13'd50;
        rand_rdy = 1'b1;
        for (int k = 0; k < BL; k++) src_q.push_back(qword(k));
        run_until_out(BL, 6000);
        repeat (40) cycle();
        rand_rdy = 1'b0;
        total++; if (out_q.size() != BL) begin bad++; $display("FAIL bp_out_count: got %0d expected %0d", out_q.size(), BL); end
        errs = 0; first_bad = -1; lasts = 0;
        for (int k = 0; k < out_q.size(); k++) begin
            if (out_q[k] !== qword(k)) begin errs++; if (first_bad < 0) first_bad = k; end
            if (out_last_q[k]) lasts++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_data: got %0d wrong words (first %0d) expected 0", errs, first_bad); end
        total++; if (lasts != 1 || out_q.size() != BL || out_last_q[BL-1] !== 1'b1) begin bad++; $display("FAIL bp_tlast: got %0d tlasts expected 1 on word %0d", lasts, BL - 1); end
        total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
        total++; if (trig_cyc_q.size() != 1) begin bad++; $display("FAIL bp_trig_count: got %0d expected 1", trig_cyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        int errs, first_bad, lasts, gap;
        reset_dut();
        threshold = 13'd50;
        for (int k = 0; k < 1100; k++) src_q.push_back(qword(k));
        run_until_out(2 * BL, 2500);
        repeat (20) cycle();
        total++; if (out_q.size() != 2 * BL) begin bad++; $display("FAIL b2b_out_count: got %0d expected %0d", out_q.size(), 2 * BL); end
        errs = 0; first_bad = -1; lasts = 0;
        // Second burst starts after 64 discarded words; its history is the 16-word refill.
        for (int k = 0; k < out_q.size(); k++) begin
            if (out_q[k] !== qword((k < BL) ? k : k + HO)) begin errs++; if (first_bad < 0) first_bad = k; end
            if (out_last_q[k]) lasts++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_data: got %0d wrong words (first %0d) expected 0", errs, first_bad); end
        total++; if (lasts != 2 || out_q.size() != 2 * BL || out_last_q[BL-1] !== 1'b1 || out_last_q[2*BL-1] !== 1'b1) begin
            bad++; $display("FAIL b2b_tlast: got %0d tlasts expected 2 on words %0d and %0d", lasts, BL - 1, 2 * BL - 1);
        end
        total++; if (trig_cyc_q.size() != 2) begin bad++; $display("FAIL b2b_trig_count: got %0d expected 2", trig_cyc_q.size()); end
        gap = (trig_cyc_q.size() >= 2) ? trig_cyc_q[1] - trig_cyc_q[0] : -1;
        total++; if (gap != BL + HO + PT) begin bad++; $display("FAIL b2b_trig_gap: got %0d cycles expected %0d", gap, BL + HO + PT); end
        total++; if (acc_cyc_q.size() != 1100) begin bad++; $display("FAIL b2b_accept: got %0d expected 1100", acc_cyc_q.size()); end
    endtask

    task automatic test_reset_mid_stream();
        int lasts;
        reset_dut();
        threshold = 13'd50;
        for (int k = 0; k < 200; k++) src_q.push_back(qword(k));
        run_until_out(40, 200);
        lasts = 0;
        foreach (out_last_q[k]) if (out_last_q[k]) lasts++;
        total++; if (out_q.size() < 40) begin bad++; $display("FAIL mid_reach_stream: got %0d words expected 40", out_q.size()); end
        rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_tvalid: got %b expected 0", m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_tready: got %b expected 0", s_ready); end
        total++; if (lasts != 0) begin bad++; $display("FAIL mid_no_tlast: got %0d tlasts expected 0", lasts); end
        reset_dut();
        threshold = 13'd50;
        for (int k = 0; k < PT - 1; k++) src_q.push_back(qword(k));
        repeat (25) cycle();
        total++; if (trig_cyc_q.size() != 0) begin bad++; $display("FAIL mid_refill_partial: got %0d pulses expected 0", trig_cyc_q.size()); end
        src_q.push_back(qword(PT - 1));
        repeat (5) cycle();
        total++; if (trig_cyc_q.size() != 1) begin bad++; $display("FAIL mid_refill_full: got %0d pulses expected 1", trig_cyc_q.size()); end
    endtask

    task automatic test_channel3();
        logic [W-1:0] w;
        int exp_trig;
        reset_dut();
        threshold = 13'd50;
        for (int k = 0; k < 20; k++) begin
            w = mk_word(0, 0, k);
            w[1*P +: P] = 12'd100;
            w[0*P +: P] = 12'd0;
            src_q.push_back(w);
        end
        repeat (30) cycle();
`ifdef AD9361_BURST_GATE_ANY_CHANNEL_EN
        exp_trig = 1;
`else
        exp_trig = 0;
`endif
        total++; if (trig_cyc_q.size() != exp_trig) begin bad++; $display("FAIL chan3_trig: got %0d pulses expected %0d", trig_cyc_q.size(), exp_trig); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold_zero();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_stream();
        test_channel3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
